// File: rtl/uart_tx_pkg.sv
// Shared types and sizing helpers for the FIFO-draining UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_e;

  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

  function automatic int frame_len(input int data_w, input int parity_en,
                                   input int stop_bits, input int clks_per_bit);
    return (1 + data_w + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high, flags the last cycle.
module baud_tick_gen
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = baud_cnt_w(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic bit_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_done = run && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO one word at a time onto a UART line:
// start bit, DATA_W data bits LSB first, optional even parity, STOP_BITS stop bits.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int IDX_W = $clog2(DATA_W) + 1;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  state_e            state;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic [IDX_W-1:0]  bit_idx;
  logic              bit_done;
  logic              baud_run;
  logic              baud_clr;

  assign fifo_pop = (state == IDLE) && en && !fifo_empty && !rst;
  assign busy     = (state != IDLE);
  assign baud_run = (state == START) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);
  assign baud_clr = (state == IDLE) || (state == LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .run      (baud_run),
    .bit_done (bit_done)
  );

  // Datapath: word captured in LOAD; shreg[0] always holds the next bit to drive.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shreg <= fifo_data;
      par   <= ^fifo_data;
    end else if (bit_done && ((state == START) || (state == DATA))) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      bit_idx     <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          bit_idx <= '0;
          if (fifo_pop) state <= LOAD;
        end
        LOAD: begin
          tx    <= 1'b0;
          state <= START;
        end
        START: begin
          if (bit_done) begin
            tx      <= shreg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            // bit_idx now counts stop bits
            if (bit_idx == LAST_STOP) begin
              bit_idx     <= '0;
              frame_count <= frame_count + 1'b1;
              state       <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity/1 stop, even parity/2 stops), each fed by a FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1, he0, he1;
  logic        fe0, fe1;
  logic [7:0]  fd0, fd1;
  logic        pop0, pop1, tx0, tx1, busy0, busy1;
  logic [15:0] fc0, fc1;

  always #5 clk = ~clk;

  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int rd0 = 0, rd1 = 0, wr0 = 0, wr1 = 0;

  assign fe0 = (rd0 == wr0) || he0;
  assign fe1 = (rd1 == wr1) || he1;

  always @(posedge clk) begin
    if (pop0) begin
      fd0 <= mem0[rd0 & 63];
      rd0 <= rd0 + 1;
    end
    if (pop1) begin
      fd1 <= mem1[rd1 & 63];
      rd1 <= rd1 + 1;
    end
  end

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .en(en0), .fifo_empty(fe0), .fifo_data(fd0),
    .fifo_pop(pop0), .tx(tx0), .busy(busy0), .frame_count(fc0));

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .en(en1), .fifo_empty(fe1), .fifo_data(fd1),
    .fifo_pop(pop1), .tx(tx1), .busy(busy1), .frame_count(fc1));

  typedef struct {
    logic [7:0] d;
    logic       p;
  } sb_t;

  typedef struct {
    int          k;
    logic [7:0]  d;
    logic        p;
    logic [15:0] fc;
  } vec_t;

  sb_t q0[$];
  sb_t q1[$];
  int  pt0[$];
  int  errs = 0, checks = 0, cyc = 0;
  int  pops0 = 0, pops1 = 0;
  logic [15:0] efc0 = 0, efc1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic txk(input int k);   return (k == 1) ? tx1 : tx0;     endfunction
  function automatic logic busyk(input int k); return (k == 1) ? busy1 : busy0; endfunction
  function automatic logic popk(input int k);  return (k == 1) ? pop1 : pop0;   endfunction
  function automatic logic fek(input int k);   return (k == 1) ? fe1 : fe0;     endfunction
  function automatic int   qsz(input int k);   return (k == 1) ? q1.size() : q0.size(); endfunction

  task automatic push(input int k, input logic [7:0] d, input logic p);
    sb_t e;
    e.d = d;
    e.p = p;
    if (k == 0) begin
      q0.push_back(e);
      mem0[wr0 & 63] = d;
      wr0++;
    end else begin
      q1.push_back(e);
      mem1[wr1 & 63] = d;
      wr1++;
    end
  endtask

  // Called at the negedge where a pop is seen; follows the whole frame cycle by cycle.
  task automatic frame_mon(input int k);
    sb_t         e;
    logic [11:0] bits;
    logic [15:0] fce;
    int          nb;
    bit          ok;
    if (k == 0) begin
      pops0++;
      pt0.push_back(cyc);
    end else begin
      pops1++;
    end
    chk($sformatf("k%0d_pop_expected", k), qsz(k) != 0, 1);
    e.d = 8'h00;
    e.p = 1'b0;
    if (qsz(k) != 0) e = (k == 1) ? q1.pop_front() : q0.pop_front();
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = e.d[i];
    nb = 9;
    if (k == 1) begin
      bits[nb] = e.p;
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (k == 1) begin
      bits[nb] = 1'b1;
      nb++;
    end
    @(negedge clk);
    if (rst) return;
    chk($sformatf("k%0d_load_tx", k), txk(k), 1);
    chk($sformatf("k%0d_load_pop", k), popk(k), 0);
    chk($sformatf("k%0d_load_busy", k), busyk(k), 1);
    for (int i = 0; i < nb; i++) begin
      ok = 1;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (rst) return;
        if (txk(k) !== bits[i] || busyk(k) !== 1'b1) ok = 0;
      end
      chk($sformatf("k%0d_word%02h_bit%0d_exp%0d", k, e.d, i, bits[i]), ok, 1);
    end
    @(negedge clk);
    if (rst) return;
    if (k == 0) begin
      efc0 = efc0 + 16'd1;
      fce  = efc0;
    end else begin
      efc1 = efc1 + 16'd1;
      fce  = efc1;
    end
    chk($sformatf("k%0d_frame_count", k), (k == 1) ? fc1 : fc0, fce);
    chk($sformatf("k%0d_busy_after_stop", k), busyk(k), 0);
    chk($sformatf("k%0d_tx_idle", k), txk(k), 1);
  endtask

  initial forever begin
    @(negedge clk);
    while (pop0 === 1'b1 && rst === 1'b0) frame_mon(0);
  end

  initial forever begin
    @(negedge clk);
    while (pop1 === 1'b1 && rst === 1'b0) frame_mon(1);
  end

  // Pops only from IDLE and never from an empty FIFO.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("k0_pop_rule", pop0 && (fe0 || busy0), 0);
      chk("k1_pop_rule", pop1 && (fe1 || busy1), 0);
    end
  end

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (n < 3000 && (busyk(k) || popk(k) || !fek(k) || qsz(k) != 0)) begin
      step();
      n++;
    end
    chk($sformatf("k%0d_wait_idle_in_budget", k), n < 3000, 1);
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  vec_t tbl[6];

  initial begin
    int  p, n;
    bit  ok;
    tbl[0] = '{0, 8'hA5, 1'b0, 16'd2};
    tbl[1] = '{1, 8'h07, 1'b1, 16'd1};
    tbl[2] = '{1, 8'h03, 1'b0, 16'd2};
    tbl[3] = '{0, 8'h00, 1'b0, 16'd3};
    tbl[4] = '{1, 8'hFF, 1'b0, 16'd3};
    tbl[5] = '{1, 8'h80, 1'b1, 16'd4};

    rst = 1'b1; en0 = 1'b1; en1 = 1'b1; he0 = 1'b0; he1 = 1'b0;
    push(0, 8'h5A, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_tx", tx0, 1);
      chk("rst_pop", pop0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_frame_count", fc0, 0);
    end
    rst = 1'b0;
    wait_idle(0);
    chk("fc0_after_first", fc0, 16'd1);

    for (int i = 0; i < 6; i++) begin
      push(tbl[i].k, tbl[i].d, tbl[i].p);
      wait_idle(tbl[i].k);
      chk($sformatf("tbl%0d_frame_count", i), (tbl[i].k == 1) ? fc1 : fc0, tbl[i].fc);
    end

    // en low with data waiting: nothing moves
    en0 = 1'b0;
    p = pops0;
    push(0, 8'h3C, 1'b0);
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx0 !== 1'b1 || pop0 !== 1'b0) ok = 0;
    end
    chk("en_low_line_idle", ok, 1);
    chk("en_low_no_pop", pops0 - p, 0);
    en0 = 1'b1;
    wait_idle(0);
    chk("en_high_fc", fc0, 16'd4);

    // en dropped mid-frame: the frame finishes, the second word waits
    p = pops0;
    push(0, 8'h81, 1'b0);
    push(0, 8'h42, 1'b0);
    n = 0;
    while (n < 100 && !busy0) begin step(); n++; end
    chk("en_drop_started", busy0, 1);
    repeat (5) step();
    en0 = 1'b0;
    n = 0;
    while (n < 200 && busy0) begin step(); n++; end
    chk("en_drop_completed", busy0, 0);
    repeat (6) step();
    chk("en_drop_pops", pops0 - p, 1);
    chk("en_drop_fc", fc0, 16'd5);
    chk("en_drop_fifo_level", wr0 - rd0, 1);
    en0 = 1'b1;
    wait_idle(0);
    chk("en_resume_fc", fc0, 16'd6);
    chk("en_resume_pops", pops0 - p, 2);

    // empty FIFO with en high: no pop
    p = pops1;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pop1 !== 1'b0 || tx1 !== 1'b1) ok = 0;
    end
    chk("empty_no_pop", ok, 1);
    he1 = 1'b1;
    push(1, 8'h99, 1'b0);
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pop1 !== 1'b0) ok = 0;
    end
    chk("empty_flag_no_pop", ok, 1);
    he1 = 1'b0;
    wait_idle(1);
    chk("empty_release_fc", fc1, 16'd5);
    chk("empty_release_pops", pops1 - p, 1);

    // back-to-back: pops every 40+2 cycles
    p = pops0;
    pt0.delete();
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b0);
    wait_idle(0);
    chk("b2b_pops", pops0 - p, 3);
    chk("b2b_pop_times", pt0.size(), 3);
    if (pt0.size() >= 3) begin
      chk("b2b_gap1", pt0[1] - pt0[0], 42);
      chk("b2b_gap2", pt0[2] - pt0[1], 42);
    end
    chk("b2b_fc", fc0, 16'd9);
    chk("b2b_fifo_empty", rd0 == wr0, 1);
    repeat (10) step();
    chk("b2b_no_fourth_pop", pops0 - p, 3);

    // reset during DATA of 0xFF
    push(0, 8'hFF, 1'b0);
    n = 0;
    while (n < 100 && !busy0) begin step(); n++; end
    chk("midrst_started", busy0, 1);
    repeat (14) step();
    rst = 1'b1;
    efc0 = 16'd0;
    efc1 = 16'd0;
    step();
    chk("midrst_tx", tx0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_fc", fc0, 16'd0);
    rst = 1'b0;
    push(0, 8'h0F, 1'b0);
    wait_idle(0);
    chk("post_rst_fc", fc0, 16'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the team's synchronous FIFO buffer. Pops one word at a time when the FIFO is non-empty and serializes it onto a UART-style line: start bit, DATA_W data bits LSB first, optional even parity, stop bit(s).
- Consumes the FIFO's registered read port: data_out is valid the cycle after pop.

Parameters:
- DATA_W, 8, width of the FIFO word and of the serial data field.
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
- PARITY_EN, 0, 1 = append even-parity bit after data bits.
- STOP_BITS, 1, number of stop bits (1 or 2).
- CNT_W, 16, width of frame_count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  enables starting new frames; an in-flight frame always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO registered data_out.
- fifo_pop  output  1  pop request to FIFO (combinational).
- tx  output  1  serial line, idle high (registered).
- busy  output  1  high whenever state != IDLE.
- frame_count  output  CNT_W  frames completed since reset, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: tx=1, fifo_pop=0, busy=0, frame_count=0, state=IDLE, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame. tx returns to 1 at the reset edge. frame_count is not incremented.
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- fifo_pop = (state==IDLE) && en && !fifo_empty && !rst.
- IDLE:
  - If fifo_pop is high, go to LOAD at the next edge.
  - Otherwise stay in IDLE with tx=1.
- LOAD (exactly 1 cycle):
  - fifo_data is valid in this cycle.
  - At the edge: shift register <= fifo_data, parity <= ^fifo_data, tx <= 0, baud counter <= 0, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then tx <= shreg[0], go to DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles, LSB first.
  - After bit DATA_W-1, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: tx = even-parity bit (XOR of data bits) for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the final edge: frame_count <= frame_count+1, go to IDLE.
- Latency: the start bit appears on tx 2 cycles after the pop cycle (pop at T0, LOAD at T1, tx=0 from T2).
- Frame length: (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles of tx.
- Back-to-back: the minimum idle-high gap between frames is 2 cycles (IDLE/pop cycle and LOAD cycle).
- Exactly one fifo_pop pulse per frame. Never pop while fifo_empty=1. Never pop outside IDLE.
- en deasserted mid-frame has no effect on the current frame. The block stays in IDLE after that frame.
- The baud counter counts 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT). It advances only in START, DATA, PARITY and STOP.
- The bit index is $clog2(DATA_W)+1 bits wide and counts stop bits as well as data bits.

Decomposition:
- Package uart_tx_pkg: state enum (IDLE, LOAD, START, DATA, PARITY, STOP) and localparam helpers (baud counter width, frame length function).
- One sub-module, baud_tick_gen: a counter with sync clear that emits bit_done on its last cycle. The FSM, shift register and frame counter stay in the top.

Test Plan:
- Reset: assert rst for 2 cycles with the FIFO holding data -> tx=1, fifo_pop=0, busy=0, frame_count=0 throughout.
- Single frame, CLKS_PER_BIT=4, PARITY_EN=0, one word 0xA5 in FIFO:
  - fifo_pop high for exactly 1 cycle, then tx=0 two cycles later.
  - tx then carries 1,0,1,0,0,1,0,1 with each bit held 4 cycles, followed by 4 high cycles.
  - frame_count=1, busy falls after the stop bit.
- Parity, PARITY_EN=1, word 0x07 -> parity bit = 1 after the data bits; word 0x03 -> parity bit = 0.
- Back-to-back, FIFO holding 0x11, 0x22, 0x33 -> 3 pop pulses, 3 correct frames, 2-cycle idle-high gap between frames, frame_count=3, FIFO empty at end, no 4th pop.
- Flow control:
  - en=0 with FIFO non-empty -> no pop, tx stays 1.
  - Drop en mid-frame -> the frame completes and no further pop occurs.
  - fifo_empty=1 with en=1 -> no pop ever issued.
- Reset mid-frame: assert rst during the DATA state of byte 0xFF -> tx=1 and busy=0 at the reset edge, frame_count unchanged (0). The next word starts with a clean start bit after rst is released.
